// File: rtl/mem_stage.sv
// Purpose: MEM pipeline stage that owns a word-organised data memory and does byte/half/word loads and stores.
// Latency: non-memory ops 1 cycle; loads/stores MEM_LAT cycles; every output is registered (MEM/WB register).
// Backpressure: stall is high for the first MEM_LAT-1 cycles of a memory op, and upstream holds its inputs.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   valid_in        an instruction is present this cycle
//   pc_in           PC of the instruction
//   alu_result      byte address for loads/stores, otherwise the result to forward
//   store_data      store operand (the low bits are used for byte/half stores)
//   wb_en           writeback enable
//   mem_read        load
//   mem_write       store
//   mem_size        00 byte, 01 half, 10/11 word
//   mem_unsigned    zero-extend loads
//   dest            destination register
//   stall           combinational; upstream must hold all inputs while high
//   valid_out       one pulse per completed instruction
//   pc_out, alu_result_out, mem_data_out, wb_en_out, mem_read_out, dest_out
//                   registered MEM/WB copies (all zero on a bubble)
//   misalign_err    one-cycle pulse that accompanies a misaligned access
module mem_stage #(
  parameter int          DEPTH     = 64,
  parameter int          MEM_LAT   = 1,
  parameter logic [31:0] BASE_ADDR = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic        wb_en,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [4:0]  dest,
  output logic        stall,
  output logic        valid_out,
  output logic [31:0] pc_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] mem_data_out,
  output logic        wb_en_out,
  output logic        mem_read_out,
  output logic [4:0]  dest_out,
  output logic        misalign_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(MEM_LAT) + 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   mem [DEPTH];

  logic          is_mem;
  logic          misalign;
  logic          done;
  logic          fire;
  logic          do_write;
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic [31:0]   rd_word;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_data;
  logic [31:0]   wr_data;
  logic [3:0]    wr_mask;

  assign is_mem = mem_read | mem_write;
  assign lane   = alu_result[1:0];

  // Subtracting the base and truncating to AW bits gives the mod-DEPTH wrap for free.
  assign idx = AW'((alu_result - BASE_ADDR) >> 2);

  always_comb begin
    misalign = 1'b0;
    if (is_mem) begin
      case (mem_size)
        2'b00:   misalign = 1'b0;
        2'b01:   misalign = lane[0];
        default: misalign = (lane != 2'b00);
      endcase
    end
  end

  // An op completes at this edge when it is either a single-cycle op seen in IDLE,
  // or the last cycle of a multi-cycle access.
  always_comb begin
    done = 1'b0;
    if (state == BUSY) begin
      done = (cnt == CNT_LAST);
    end else begin
      done = !is_mem || (MEM_LAT == 1);
    end
  end

  assign fire     = valid_in && done && !rst;
  assign do_write = fire && mem_write && !misalign;

  always_comb begin
    stall = 1'b0;
    if (!rst) begin
      if (state == BUSY) begin
        stall = (cnt != CNT_LAST);
      end else begin
        stall = valid_in && is_mem && (MEM_LAT > 1);
      end
    end
  end

  // Load path: the array read is asynchronous, so the registered result reflects
  // memory contents before any store landing on the same edge.
  assign rd_word = mem[idx];
  assign ld_byte = rd_word[{lane, 3'b000} +: 8];
  assign ld_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    ld_data = rd_word;
    case (mem_size)
      2'b00:   ld_data = mem_unsigned ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = mem_unsigned ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_data = rd_word;
    endcase
  end

  // Store path: replicate the operand across lanes and let the mask pick the lane(s).
  always_comb begin
    wr_mask = 4'b1111;
    wr_data = store_data;
    case (mem_size)
      2'b00: begin
        wr_mask = 4'b0001 << lane;
        wr_data = {4{store_data[7:0]}};
      end
      2'b01: begin
        wr_mask = lane[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{store_data[15:0]}};
      end
      default: begin
        wr_mask = 4'b1111;
        wr_data = store_data;
      end
    endcase
  end

  // Data memory is deliberately not reset; rst still blocks a pending store via do_write.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_mask[b]) begin
          mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      valid_out      <= 1'b0;
      pc_out         <= '0;
      alu_result_out <= '0;
      mem_data_out   <= '0;
      wb_en_out      <= 1'b0;
      mem_read_out   <= 1'b0;
      dest_out       <= '0;
      misalign_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_in && is_mem && (MEM_LAT > 1)) begin
            state <= BUSY;
            cnt   <= CNT_ONE;
          end
        end
        BUSY: begin
          if (cnt == CNT_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase

      if (fire) begin
        valid_out      <= 1'b1;
        pc_out         <= pc_in;
        alu_result_out <= alu_result;
        // A read+write op is treated as a store, so it returns no load data.
        mem_data_out   <= (mem_read && !mem_write && !misalign) ? ld_data : 32'h0;
        wb_en_out      <= wb_en && !misalign;
        mem_read_out   <= mem_read && !mem_write;
        dest_out       <= dest;
        misalign_err   <= misalign;
      end else begin
        valid_out      <= 1'b0;
        pc_out         <= '0;
        alu_result_out <= '0;
        mem_data_out   <= '0;
        wb_en_out      <= 1'b0;
        mem_read_out   <= 1'b0;
        dest_out       <= '0;
        misalign_err   <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Pipelined memory-access stage of the five-stage processor, sitting between the EX/MEM and MEM/WB boundaries. It is the parametrised successor of the pass-through memory stage: it owns a word-organised data memory, performs byte/half/word loads and stores with sign or zero extension, and supports a configurable multi-cycle access latency with a stall handshake to upstream stages. All outputs are registered and form the MEM/WB pipeline register.

## Interface
- DEPTH, 64: data memory size in 32-bit words; power of two.
- MEM_LAT, 1: access latency in cycles for loads/stores; ≥1.
- BASE_ADDR, 1024: byte address mapped to word 0.

- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_in  in  1  instruction present this cycle.
- pc_in  in  32  PC of instruction.
- alu_result  in  32  byte address for memory ops, else result to forward.
- store_data  in  32  store operand (low bits used for byte/half).
- wb_en  in  1  writeback enable.
- mem_read  in  1  load.
- mem_write  in  1  store.
- mem_size  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- mem_unsigned  in  1  zero-extend loads when 1.
- dest  in  5  destination register.
- stall  out  1  combinational; upstream must hold all inputs while 1.
- valid_out  out  1  registered; one pulse per completed instruction.
- pc_out, alu_result_out  out  32  registered copies.
- mem_data_out  out  32  registered extended load data.
- wb_en_out, mem_read_out  out  1  registered.
- dest_out  out  5  registered.
- misalign_err  out  1  registered; one-cycle pulse with the faulting instruction.

## Operation
- Word index = ((alu_result − BASE_ADDR) >> 2) mod DEPTH; out-of-range addresses wrap, no error.
- Byte lane = alu_result[1:0], little-endian. Store byte writes lane only; half writes lanes {1,0} or {3,2}; word writes all.
- Load: selected byte/half sign-extended unless mem_unsigned; word unchanged.
- Misaligned: half with addr[0]=1, word with addr[1:0]≠0 → no write, mem_data_out=0, wb_en_out=0, misalign_err=1.
- mem_read and mem_write both 1 → store performed, mem_data_out=0, mem_read_out=0.
- Non-memory instruction (valid_in, neither read nor write): pass-through, mem_data_out=0, never stalls.
- valid_in=0: valid_out=0, all other registered outputs 0 (bubble).
- FSM: IDLE, BUSY; counter cnt of width clog2(MEM_LAT)+1.
  - IDLE, valid memory op, MEM_LAT=1: commit at this edge, stay IDLE, stall=0.
  - IDLE, valid memory op, MEM_LAT>1: stall=1, → BUSY, cnt=1; outputs load bubble.
  - BUSY, cnt<MEM_LAT−1: stall=1, cnt++, bubble.
  - BUSY, cnt=MEM_LAT−1: stall=0, commit (write memory / capture read), register outputs, → IDLE.
- Store commits only on the completing edge; no partial effect earlier.
- Load reads memory contents as of the completing edge (before any same-edge write).

## Timing
- Reset: state IDLE, cnt=0, every output 0 (including stall=0 during rst). Memory contents not reset.
- Reset during BUSY: operation aborted, pending store discarded, next cycle IDLE.
- Latency: non-memory op 1 cycle; memory op MEM_LAT cycles from first presentation to valid_out; stall high for the first MEM_LAT−1 of those cycles.
- Throughput: one op per cycle at MEM_LAT=1; back-to-back memory ops at MEM_LAT=L complete every L cycles.
- Inputs changing while stall=1 are a protocol violation; the block uses values sampled on the completing edge.

## Test plan
- MEM_LAT=1: store word 0xDEADBEEF to 1028, then load word 1028 → next cycle mem_data_out=0xDEADBEEF, valid_out=1, dest_out echoed, stall never 1.
- Byte/half extension: word 0x80F07F01 at 1032; lb 1035 → 0xFFFFFF80; lbu 1035 → 0x00000080; lh 1034 → 0xFFFF80F0; lhu 1032 → 0x00007F01; sb 0xAA at 1033 then lw → 0x80F0AA01.
- Misaligned lw at 1030 → misalign_err=1, wb_en_out=0, mem_data_out=0, memory unchanged.
- MEM_LAT=3: load presented cycle 0 → stall=1 cycles 0–1, 0 in cycle 2, valid_out=1 in cycle 3 only; following ALU op held during stall then exits cycle 4.
- MEM_LAT=3: assert rst in cycle 1 of a store of 0x12345678 to 1024 → memory word 0 unchanged, all outputs 0, state IDLE.
- Wrap: DEPTH=64, store to 1024+256 then load 1024 → returns stored value.
